// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the single shared synchronous memory port between instruction
// fetch, data load/store and (optionally) a debug reader. Each access takes a
// grant cycle (IDLE, fields driven combinationally to the memory) followed by a
// WAIT cycle (read data returns); the requester's rvalid pulses one cycle later.
// Optional debug requester: define MEMARB_DEBUG_PORT_EN to build the g_* ports,
// the starvation counter and the forced-debug override.
module mem_port_arbiter #(
    parameter int AW = 10
`ifdef MEMARB_DEBUG_PORT_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [31:0]   d_wdata,
    input  logic [1:0]    d_width,
    input  logic          d_sign,
    output logic          d_gnt,
    output logic          d_rvalid,
`ifdef MEMARB_DEBUG_PORT_EN
    input  logic          g_req,
    input  logic [AW-1:0] g_addr,
    output logic          g_gnt,
    output logic          g_rvalid,
`endif
    output logic [31:0]   rdata,
    output logic          busy,
    output logic [AW-1:0] mem_address,
    output logic [31:0]   mem_in,
    output logic          mem_wren,
    output logic [1:0]    mem_width,
    output logic          mem_sign,
    input  logic [31:0]   mem_out
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [1:0] ID_FETCH   = 2'd0;
    localparam logic [1:0] ID_DATA    = 2'd1;
    localparam logic [1:0] ID_DEBUG   = 2'd2;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    state_t          state_reg, state_next;
    logic [1:0]      id_reg;
    logic [AW-1:0]   addr_reg;
    logic            store_reg;
    logic [1:0]      width_reg;
    logic            sign_reg;
    logic            f_rvalid_reg, d_rvalid_reg;
    logic [31:0]     rdata_reg;
    logic            win_f, win_d, win_g;
    logic            force_g;
    logic            g_req_int;
    logic [AW-1:0]   g_addr_int;

`ifdef MEMARB_DEBUG_PORT_EN
    logic [3:0]      starve_cnt_reg;
    logic            g_rvalid_reg;

    assign g_req_int  = g_req;
    assign g_addr_int = g_addr;
    // A debug request that has been denied STARVE_LIMIT times beats everyone.
    assign force_g    = g_req && (starve_cnt_reg == 4'(STARVE_LIMIT));
    assign g_gnt      = win_g;
    assign g_rvalid   = g_rvalid_reg;

    // Starvation counter: counts IDLE cycles where debug waited and lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg <= 4'd0;
        end else if (win_g) begin
            starve_cnt_reg <= 4'd0;
        end else if (g_req && (win_d || win_f) && (starve_cnt_reg < 4'(STARVE_LIMIT))) begin
            starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
    end

    // Debug completion pulse, issued the cycle after WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_rvalid_reg <= 1'b0;
        end else begin
            g_rvalid_reg <= (state_reg == S_WAIT) && (id_reg == ID_DEBUG);
        end
    end
`else
    assign g_req_int  = 1'b0;
    assign g_addr_int = '0;
    assign force_g    = 1'b0;
`endif

    // Winner selection: only in IDLE, never while reset is asserted.
    always_comb begin
        win_f = 1'b0;
        win_d = 1'b0;
        win_g = 1'b0;
        if ((state_reg == S_IDLE) && rst) begin
            if (force_g) begin
                win_g = 1'b1;
            end else if (d_req) begin
                win_d = 1'b1;
            end else if (f_req) begin
                win_f = 1'b1;
            end else if (g_req_int) begin
                win_g = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: any grant starts an access, WAIT always lasts one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (win_f || win_d || win_g) state_next = S_WAIT;
            S_WAIT:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: grant cycle drives the winner's fields, WAIT replays the captured access.
    always_comb begin
        f_gnt       = win_f;
        d_gnt       = win_d;
        busy        = (state_reg == S_WAIT);
        mem_in      = d_wdata;
        mem_address = f_addr;
        mem_wren    = 1'b0;
        mem_width   = WIDTH_WORD;
        mem_sign    = 1'b0;
        if (state_reg == S_WAIT) begin
            mem_address = addr_reg;
            mem_width   = width_reg;
            mem_sign    = sign_reg;
        end else if (win_d) begin
            mem_address = d_addr;
            mem_wren    = d_we;
            mem_width   = d_width;
            mem_sign    = d_sign;
        end else if (win_g) begin
            mem_address = g_addr_int;
        end
    end

    // Capture the granted access so WAIT and completion know who owns the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_reg    <= ID_FETCH;
            addr_reg  <= '0;
            store_reg <= 1'b0;
            width_reg <= WIDTH_WORD;
            sign_reg  <= 1'b0;
        end else if (win_d) begin
            id_reg    <= ID_DATA;
            addr_reg  <= d_addr;
            store_reg <= d_we;
            width_reg <= d_width;
            sign_reg  <= d_sign;
        end else if (win_f) begin
            id_reg    <= ID_FETCH;
            addr_reg  <= f_addr;
            store_reg <= 1'b0;
            width_reg <= WIDTH_WORD;
            sign_reg  <= 1'b0;
        end else if (win_g) begin
            id_reg    <= ID_DEBUG;
            addr_reg  <= g_addr_int;
            store_reg <= 1'b0;
            width_reg <= WIDTH_WORD;
            sign_reg  <= 1'b0;
        end
    end

    // Completion: latch load data at the end of WAIT and pulse the owner's valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            rdata_reg    <= 32'd0;
        end else begin
            f_rvalid_reg <= (state_reg == S_WAIT) && (id_reg == ID_FETCH);
            d_rvalid_reg <= (state_reg == S_WAIT) && (id_reg == ID_DATA);
            if ((state_reg == S_WAIT) && !store_reg) begin
                rdata_reg <= mem_out;
            end
        end
    end

    assign f_rvalid = f_rvalid_reg;
    assign d_rvalid = d_rvalid_reg;
    assign rdata    = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a synchronous memory model.
// Directed scenarios followed by a randomized run scored against a
// transaction-level reference model. Honors MEMARB_DEBUG_PORT_EN.
module tb_mem_port_arbiter;

    localparam int AW    = 10;
    localparam int LIMIT = 4;
    localparam int F = 0, D = 1, G = 2, NONE = 3;
`ifdef MEMARB_DEBUG_PORT_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    typedef struct {
        int            due;
        int            id;
        bit            st;
        logic [31:0]   data;
        logic [AW-1:0] addr;
    } acc_t;

    logic          clk;
    logic          rst = 1'b1;
    logic          f_req, f_gnt, f_rvalid;
    logic [AW-1:0] f_addr;
    logic          d_req, d_we, d_sign, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [1:0]    d_width;
    logic          g_req, g_gnt, g_rvalid;
    logic [AW-1:0] g_addr;
    logic [31:0]   rdata, mem_in, mem_out;
    logic          busy, mem_wren, mem_sign;
    logic [AW-1:0] mem_address;
    logic [1:0]    mem_width;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    logic [31:0]   mem     [0:1023];
    logic          mem_vld [0:1023];
    logic [31:0]   ref_mem [0:1023];

    int            checks, errors, cyc;
    logic [31:0]   last_rdata;

    mem_port_arbiter #(
        .AW(AW)
`ifdef MEMARB_DEBUG_PORT_EN
        ,
        .STARVE_LIMIT(LIMIT)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_width(d_width), .d_sign(d_sign), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
`ifdef MEMARB_DEBUG_PORT_EN
        .g_req(g_req), .g_addr(g_addr), .g_gnt(g_gnt), .g_rvalid(g_rvalid),
`endif
        .rdata(rdata), .busy(busy),
        .mem_address(mem_address), .mem_in(mem_in), .mem_wren(mem_wren),
        .mem_width(mem_width), .mem_sign(mem_sign), .mem_out(mem_out)
    );

`ifndef MEMARB_DEBUG_PORT_EN
    assign g_gnt    = 1'b0;
    assign g_rvalid = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        return {a, 6'h2a, ~a, 6'h15};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'(32'h200 + ($urandom_range(0, 15) << 2));
    endfunction

    // Synchronous memory: write on wren, registered read one cycle later.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr]     <= pl_data;
            mem_vld[pl_addr] <= 1'b1;
        end else if (mem_wren) begin
            mem[mem_address]     <= mem_in;
            mem_vld[mem_address] <= 1'b1;
        end
        mem_out <= (mem_vld[mem_address] === 1'b1) ? mem[mem_address] : init_word(mem_address);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
        tick();
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        tick();
        pl_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        f_req = 1'b1; f_addr = 10'h010;
        #1;
        checks++; if ({f_gnt, d_gnt, g_gnt} !== 3'b000) begin errors++; $display("FAIL rst_gnt_gated: got %b expected 000", {f_gnt, d_gnt, g_gnt}); end
        checks++; if ({f_rvalid, d_rvalid, g_rvalid} !== 3'b000) begin errors++; $display("FAIL rst_rvalid: got %b expected 000", {f_rvalid, d_rvalid, g_rvalid}); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        checks++; if (busy !== 1'b0 || mem_wren !== 1'b0) begin errors++; $display("FAIL rst_busy_wren: got %b%b expected 00", busy, mem_wren); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (f_gnt !== 1'b1 || mem_address !== 10'h010) begin errors++; $display("FAIL rst_fetch_gnt: got gnt=%b addr=%h expected 1 010", f_gnt, mem_address); end
        tick();
        f_req = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: got %b expected 1", busy); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (f_rvalid !== 1'b0 || rdata !== 32'd0 || busy !== 1'b0 || mem_wren !== 1'b0) begin
                errors++;
                $display("FAIL rst_after: got rvalid=%b rdata=%h busy=%b wren=%b expected 0 0 0 0", f_rvalid, rdata, busy, mem_wren);
            end
        end
        tick();
        rst = 1'b1;
        last_rdata = 32'd0;
        $display("txn reset-mid-access done");
    endtask

    task automatic test_single_fetch();
        preload(10'h004, 32'h00500093);
        tick();
        f_req = 1'b1; f_addr = 10'h004;
        #1;
        checks++; if ({g_gnt, d_gnt, f_gnt} !== 3'b001) begin errors++; $display("FAIL fetch_gnt: got %b expected 001", {g_gnt, d_gnt, f_gnt}); end
        checks++; if (mem_address !== 10'h004 || mem_wren !== 1'b0 || mem_width !== 2'b10) begin errors++; $display("FAIL fetch_mem: got addr=%h wren=%b width=%b expected 004 0 10", mem_address, mem_wren, mem_width); end
        tick();
        f_req = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || f_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_wait: got busy=%b rvalid=%b expected 1 0", busy, f_rvalid); end
        tick();
        #1;
        checks++; if (f_rvalid !== 1'b1 || rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_data: got rvalid=%b rdata=%h expected 1 00500093", f_rvalid, rdata); end
        last_rdata = 32'h00500093;
        $display("txn fetch addr=004 rdata=%h", rdata);
    endtask

    task automatic test_collision();
        tick();
        f_req = 1'b1; f_addr = 10'h008;
        d_req = 1'b1; d_addr = 10'h100; d_we = 1'b0; d_width = 2'b10; d_sign = 1'b0;
        #1;
        checks++; if ({f_gnt, d_gnt} !== 2'b01 || mem_address !== 10'h100) begin errors++; $display("FAIL coll_first: got f=%b d=%b addr=%h expected 0 1 100", f_gnt, d_gnt, mem_address); end
        tick();
        d_req = 1'b0;
        #1;
        checks++; if (f_gnt !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL coll_wait: got f_gnt=%b busy=%b expected 0 1", f_gnt, busy); end
        tick();
        #1;
        checks++; if ({f_gnt, d_rvalid, f_rvalid} !== 3'b110) begin errors++; $display("FAIL coll_second: got f_gnt,d_rv,f_rv=%b expected 110", {f_gnt, d_rvalid, f_rvalid}); end
        checks++; if (rdata !== ref_mem[10'h100]) begin errors++; $display("FAIL coll_ddata: got %h expected %h", rdata, ref_mem[10'h100]); end
        $display("txn load addr=100 rdata=%h", rdata);
        tick();
        f_req = 1'b0;
        tick();
        #1;
        checks++; if (f_rvalid !== 1'b1 || rdata !== ref_mem[10'h008]) begin errors++; $display("FAIL coll_fdata: got rv=%b rdata=%h expected 1 %h", f_rvalid, rdata, ref_mem[10'h008]); end
        last_rdata = ref_mem[10'h008];
        $display("txn fetch addr=008 rdata=%h", rdata);
    endtask

    task automatic test_store();
        logic [31:0] prev;
        prev = last_rdata;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h040; d_wdata = 32'hDEADBEEF; d_width = 2'b10;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_in !== 32'hDEADBEEF || mem_address !== 10'h040) begin errors++; $display("FAIL store_grant: got gnt=%b wren=%b in=%h addr=%h expected 1 1 deadbeef 040", d_gnt, mem_wren, mem_in, mem_address); end
        ref_mem[10'h040] = 32'hDEADBEEF;
        tick();
        d_req = 1'b0; d_we = 1'b0;
        #1;
        checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL store_wren_once: got %b expected 0", mem_wren); end
        tick();
        #1;
        checks++; if (d_rvalid !== 1'b1 || rdata !== prev || mem_wren !== 1'b0) begin errors++; $display("FAIL store_ack: got rv=%b rdata=%h wren=%b expected 1 %h 0", d_rvalid, rdata, mem_wren, prev); end
        $display("txn store addr=040 data=deadbeef");
        tick();
        d_req = 1'b1; d_addr = 10'h040;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_wren !== 1'b0) begin errors++; $display("FAIL reload_gnt: got gnt=%b wren=%b expected 1 0", d_gnt, mem_wren); end
        tick();
        d_req = 1'b0;
        tick();
        #1;
        checks++; if (d_rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL reload_data: got rv=%b rdata=%h expected 1 deadbeef", d_rvalid, rdata); end
        last_rdata = 32'hDEADBEEF;
        $display("txn load addr=040 rdata=%h", rdata);
    endtask

    task automatic test_starvation();
        int            prev;
        bit            want_g;
        logic [AW-1:0] prev_addr, cur_addr;
        logic [31:0]   exp_rd;
        prev = NONE; prev_addr = '0;
        cur_addr = rand_addr();
        for (int k = 0; k < 10; k++) begin
            tick();
            f_req = 1'b0;
            d_req = 1'b1; d_we = 1'b0; d_addr = cur_addr; d_width = 2'b10; d_sign = 1'b0;
            g_req = 1'b1; g_addr = 10'h0C0;
            #1;
            want_g = (k % 5) == 4;
            checks++;
            if ({g_gnt, d_gnt, f_gnt} !== {want_g, !want_g, 1'b0}) begin
                errors++;
                $display("FAIL starve_gnt idle#%0d: got g,d,f=%b expected %b", k + 1, {g_gnt, d_gnt, f_gnt}, {want_g, !want_g, 1'b0});
            end
            if (prev != NONE) begin
                exp_rd = ref_mem[prev_addr];
                checks++;
                if ({g_rvalid, d_rvalid} !== {prev == G, prev == D} || rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL starve_rvalid idle#%0d: got g,d=%b rdata=%h expected %b %h", k + 1, {g_rvalid, d_rvalid}, rdata, {prev == G, prev == D}, exp_rd);
                end
                last_rdata = exp_rd;
                $display("txn starve id=%0d addr=%h rdata=%h", prev, prev_addr, rdata);
            end
            prev      = want_g ? G : D;
            prev_addr = want_g ? 10'h0C0 : cur_addr;
            tick();
            if (!want_g) begin
                cur_addr = rand_addr();
                d_addr   = cur_addr;
            end
            #1;
            checks++; if ({g_gnt, d_gnt, f_gnt} !== 3'b000) begin errors++; $display("FAIL starve_wait: got %b expected 000", {g_gnt, d_gnt, f_gnt}); end
        end
        tick();
        d_req = 1'b0; g_req = 1'b0;
        #1;
        exp_rd = ref_mem[prev_addr];
        checks++; if (g_rvalid !== 1'b1 || rdata !== exp_rd) begin errors++; $display("FAIL starve_last: got rv=%b rdata=%h expected 1 %h", g_rvalid, rdata, exp_rd); end
        last_rdata = exp_rd;
        $display("txn starve id=%0d addr=%h rdata=%h", prev, prev_addr, rdata);
    endtask

    task automatic test_random(input int n);
        bit            fp, dp, gp, dwe, can, frc;
        logic [AW-1:0] fa, da, ga;
        logic [31:0]   dwd, exp_rd;
        logic [2:0]    exp_g, exp_v;
        int            won, w, starve, last_gnt;
        acc_t          q[$];
        acc_t          a;
        fp = 0; dp = 0; gp = 0; dwe = 0; fa = '0; da = '0; ga = '0; dwd = '0;
        won = NONE; starve = 0;
        f_req = 0; d_req = 0; g_req = 0;
        repeat (3) tick();
        last_gnt = cyc - 100;
        for (int c = 0; c < n + 12; c++) begin
            tick();
            if (won == F) fp = 0;
            if (won == D) dp = 0;
            if (won == G) gp = 0;
            if (c < n) begin
                if (!fp && $urandom_range(0, 2) == 0) begin fp = 1; fa = rand_addr(); end
                if (!dp && $urandom_range(0, 2) == 0) begin dp = 1; da = rand_addr(); dwe = 1'($urandom_range(0, 1)); dwd = $urandom; end
                if (DBG && !gp && $urandom_range(0, 3) == 0) begin gp = 1; ga = rand_addr(); end
            end
            f_req = fp; f_addr = fa;
            d_req = dp; d_addr = da; d_we = dwe; d_wdata = dwd; d_width = 2'b10; d_sign = 1'b0;
            g_req = gp; g_addr = ga;
            #1;
            can = (cyc - last_gnt) >= 2;
            frc = DBG && gp && (starve == LIMIT);
            w = NONE;
            if (can) begin
                if (frc) w = G;
                else if (dp) w = D;
                else if (fp) w = F;
                else if (gp) w = G;
            end
            exp_g = {w == G, w == D, w == F};
            checks++; if ({g_gnt, d_gnt, f_gnt} !== exp_g) begin errors++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", cyc, {g_gnt, d_gnt, f_gnt}, exp_g); end
            checks++; if (mem_wren !== (w == D && dwe)) begin errors++; $display("FAIL rnd_wren cyc %0d: got %b expected %b", cyc, mem_wren, (w == D && dwe)); end
            if (w != NONE) begin
                a.addr = (w == D) ? da : (w == F) ? fa : ga;
                checks++; if (mem_address !== a.addr) begin errors++; $display("FAIL rnd_addr cyc %0d: got %h expected %h", cyc, mem_address, a.addr); end
            end
            checks++; if (busy !== ((cyc - last_gnt) == 1)) begin errors++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, busy, ((cyc - last_gnt) == 1)); end
            exp_v  = 3'b000;
            exp_rd = last_rdata;
            if (q.size() > 0 && q[0].due == cyc) begin
                a = q.pop_front();
                exp_v[a.id] = 1'b1;
                if (!a.st) exp_rd = a.data;
                $display("txn rnd id=%0d addr=%h store=%0d rdata=%h", a.id, a.addr, a.st, rdata);
            end
            checks++; if ({g_rvalid, d_rvalid, f_rvalid} !== exp_v) begin errors++; $display("FAIL rnd_rvalid cyc %0d: got %b expected %b", cyc, {g_rvalid, d_rvalid, f_rvalid}, exp_v); end
            checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata cyc %0d: got %h expected %h", cyc, rdata, exp_rd); end
            last_rdata = exp_rd;
            if (w != NONE) begin
                a.due  = cyc + 2;
                a.id   = w;
                a.addr = (w == D) ? da : (w == F) ? fa : ga;
                a.st   = (w == D) && dwe;
                a.data = ref_mem[a.addr];
                q.push_back(a);
                last_gnt = cyc;
                if (a.st) ref_mem[a.addr] = dwd;
            end
            if (can && gp) begin
                if (w == G) starve = 0;
                else if (w != NONE && starve < LIMIT) starve++;
            end
            won = w;
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d outstanding expected 0", q.size()); end
        f_req = 0; d_req = 0; g_req = 0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_rdata = 32'd0;
        f_req = 0; f_addr = '0; d_req = 0; d_addr = '0; d_we = 0; d_wdata = '0;
        d_width = 2'b10; d_sign = 0; g_req = 0; g_addr = '0;
        pl_en = 0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(AW'(i));
        #2;
        rst = 1'b0;
        test_reset();
        test_single_fetch();
        test_collision();
        test_store();
`ifdef MEMARB_DEBUG_PORT_EN
        test_starvation();
`endif
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared synchronous memory port in the multicycle processor. It grants the port to one of three requesters per access and returns read data with a per-requester valid pulse: instruction fetch, data load/store, and an optional switch-driven debug reader. The Control FSM issues fetch and data requests through it instead of steering the memory address mux directly.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive IDLE cycles a pending debug request may be denied before it is forced to win; legal 1..15.
- `AW`, default 10: memory address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch request; held until `f_gnt`.
- `f_addr` in AW: fetch address.
- `f_gnt` out 1: fetch granted, combinational one-cycle pulse.
- `f_rvalid` out 1: fetch data valid on `rdata`, one-cycle pulse.
- `d_req` in 1: data request; held with its fields stable until `d_gnt`.
- `d_addr` in AW: data address.
- `d_we` in 1: 1 = store, 0 = load.
- `d_wdata` in 32: store data.
- `d_width` in 2: access width, same encoding as the memory.
- `d_sign` in 1: load sign-extend.
- `d_gnt`, `d_rvalid` out 1: same meaning as the fetch pair.
- `g_req`, `g_addr`, `g_gnt`, `g_rvalid`: debug requester, same meaning as the fetch signals; present only with `MEMARB_DEBUG_PORT_EN`.
- `rdata` out 32: registered read data shared by all requesters.
- `busy` out 1: high in WAIT.
- `mem_address` out AW, `mem_in` out 32, `mem_wren` out 1, `mem_width` out 2, `mem_sign` out 1: memory-side controls.
- `mem_out` in 32: memory read data, valid the cycle after the address is presented.

## Operation
- FSM states: IDLE and WAIT.
  - IDLE to WAIT when any request wins.
  - WAIT to IDLE unconditionally.
- Arbitration in IDLE uses fixed priority: data, then fetch, then debug.
  - Override: when the starvation counter equals `STARVE_LIMIT` and `g_req` is high, debug wins.
- Starvation counter (4 bit):
  - Increments in each IDLE cycle where `g_req`=1 and another requester wins; saturates at `STARVE_LIMIT`.
  - Clears on `g_gnt`.
  - Holds otherwise, including in WAIT.
- The grant cycle drives the winner's fields onto the `mem_*` outputs combinationally. The winner's id is registered for WAIT.
- Fetch and debug accesses force `mem_width`=2'b10 (word), `mem_sign`=0, `mem_wren`=0.
- `mem_wren` = `d_we` only in a data-grant cycle; it is 0 in all other cycles.
- In WAIT: `mem_wren`=0, `mem_address` holds the granted address, and `rdata` captures `mem_out` at the end of the cycle.
- On the next cycle the registered valid for the granted id pulses.
  - Stores also pulse `d_rvalid` as a write acknowledge.
  - For stores, `rdata` is not updated.
- Requests seen during WAIT get no grant; the requester keeps waiting.
- IDLE with no request: `mem_address`=`f_addr`, `mem_wren`=0.

## Timing
- Reset values: state IDLE, all `*_gnt`=0 (gated while `rst`=0), all `*_rvalid`=0, `rdata`=0, `busy`=0, `mem_wren`=0, starvation counter 0, registered id = fetch.
- Latency: grant in cycle N, `rvalid` and `rdata` in cycle N+2.
- Throughput: one access per 2 cycles. A new grant may coincide with the previous access's `rvalid` pulse.
- Simultaneous requests: exactly one `*_gnt` per grant cycle. Losers see no pulse and must hold their request.
- Reset mid-access: the FSM returns to IDLE and no `rvalid` is issued. A store already presented with `mem_wren` in the grant cycle has been committed. Requesters re-request after reset.
- `f_rvalid`, `d_rvalid` and `g_rvalid` are mutually exclusive.

## Configuration
- `MEMARB_DEBUG_PORT_EN` defined:
  - `g_*` ports exist.
  - The starvation counter and override logic are built.
- `MEMARB_DEBUG_PORT_EN` undefined:
  - `g_*` ports, counter and `STARVE_LIMIT` logic are removed.
  - Arbitration is data over fetch only.

## Test plan
- Reset: assert `rst`=0 mid-WAIT after a fetch grant of addr 0x010 → no `f_rvalid`, `rdata`=0, `busy`=0, `mem_wren`=0.
- Single fetch: `f_req`=1 with `f_addr`=0x004, memory word 0x00500093 → `f_gnt` in cycle N; `f_rvalid`=1 and `rdata`=0x00500093 in N+2.
- Collision: `f_req` and `d_req` both high in the same cycle, load from 0x100 → `d_gnt` in N, `f_gnt` in N+2, and `d_rvalid` in N+2 together with `f_gnt`.
- Store: `d_we`=1, `d_addr`=0x040, `d_wdata`=0xDEADBEEF, width word → `mem_wren`=1 for exactly one cycle, `d_rvalid` in N+2 with `rdata` unchanged; a subsequent load of 0x040 returns 0xDEADBEEF.
- Starvation (macro on, `STARVE_LIMIT`=4): hold `d_req` continuously and `g_req` high → debug granted on the 5th IDLE cycle; the counter then reads 0.
- Macro off: `d_req`/`f_req` alternate for 20 accesses → each `rvalid` matches its requester, and there are no double grants.
